// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode encoding, FSM state and
// the classifier that separates single-cycle ops from RUN-phase ops.
package alu_pkg;

  typedef enum logic [3:0] {
    ADD = 4'd0,
    SUB = 4'd1,
    XOR = 4'd2,
    GST = 4'd3,
    SH1 = 4'd4,
    ACC = 4'd5,
    ENQ = 4'd6,
    EQI = 4'd7,
    FBT = 4'd8,
    BRC = 4'd9,
    BRR = 4'd10,
    SHN = 4'd11,
    MUL = 4'd12,
    POP = 4'd13
  } alu_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // True for ops that need the iterative engine (more than one edge).
  function automatic logic is_iter(input alu_op_t op);
    case (op)
      SHN, MUL, POP: return 1'b1;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result bundle between the controller (master) and the ALU (slave).
interface alu_seq_if #(
  parameter int W    = 8,
  parameter int IMMW = 5,
  parameter int OFFW = W + 1
);
  logic            START;
  logic [3:0]      OP;
  logic            T;
  logic [W-1:0]    INPUTA;
  logic [W-1:0]    INPUTB;
  logic [IMMW-1:0] IMM;
  logic [W-1:0]    OUT;
  logic [W-1:0]    OUT_HI;
  logic            ZERO;
  logic            CARRY;
  logic            BUSY;
  logic            DONE;
  logic [OFFW-1:0] bOFFSET;
  logic            bSIGN;

  modport master (
    output START, OP, T, INPUTA, INPUTB, IMM,
    input  OUT, OUT_HI, ZERO, CARRY, BUSY, DONE, bOFFSET, bSIGN
  );

  modport slave (
    input  START, OP, T, INPUTA, INPUTB, IMM,
    output OUT, OUT_HI, ZERO, CARRY, BUSY, DONE, bOFFSET, bSIGN
  );
endinterface

// File: rtl/alu_iter.sv
// RUN-phase engine: one bit of shift, one shift-add multiply step or one
// popcount step per edge. Results are presented combinationally on the
// final step so the top can register them at that same edge.
module alu_iter
  import alu_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          run,
  input  alu_op_t       op,
  input  logic          dir,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic [CW-1:0] count,
  output logic          done,
  output logic [W-1:0]  res_lo,
  output logic [W-1:0]  res_hi,
  output logic          res_carry
);

  alu_op_t       op_r;
  logic          dir_r;
  logic          shift_en_r;
  logic [CW-1:0] steps_r;
  logic [W-1:0]  a_r;
  logic [W-1:0]  lo_r;
  logic [W-1:0]  hi_r;
  logic          carry_r;

  logic [W-1:0]  lo_s;
  logic [W-1:0]  hi_s;
  logic          carry_s;
  logic [W:0]    sum_s;

  // One iteration of the latched op, computed from the working registers.
  always_comb begin
    lo_s    = lo_r;
    hi_s    = hi_r;
    carry_s = carry_r;
    sum_s   = {(W+1){1'b0}};
    case (op_r)
      SHN: begin
        if (shift_en_r) begin
          if (dir_r) begin
            carry_s = lo_r[0];
            lo_s    = {1'b0, lo_r[W-1:1]};
          end else begin
            carry_s = lo_r[W-1];
            lo_s    = {lo_r[W-2:0], 1'b0};
          end
        end else begin
          carry_s = 1'b0;
          lo_s    = lo_r;
        end
      end
      MUL: begin
        // hi accumulates partial sums; lo holds the multiplier and fills
        // with product bits as it shifts right.
        sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, a_r} : {(W+1){1'b0}});
        hi_s    = sum_s[W:1];
        lo_s    = {sum_s[0], lo_r[W-1:1]};
        carry_s = 1'b0;
      end
      POP: begin
        hi_s = hi_r + {{(W-1){1'b0}}, lo_r[0]};
        lo_s = {1'b0, lo_r[W-1:1]};
      end
      default: begin
        lo_s = lo_r;
      end
    endcase
  end

  // Final-step flag and op-specific view of the post-step values.
  always_comb begin
    done      = run && (steps_r == {{(CW-1){1'b0}}, 1'b1});
    res_lo    = lo_s;
    res_hi    = {W{1'b0}};
    res_carry = 1'b0;
    case (op_r)
      SHN: begin
        res_carry = carry_s;
      end
      MUL: begin
        res_hi    = hi_s;
        res_carry = (hi_s != {W{1'b0}});
      end
      POP: begin
        res_lo = hi_s;
      end
      default: begin
        res_lo = lo_s;
      end
    endcase
  end

  // Latch operands on start, then advance one step per edge while running.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r       <= ADD;
      dir_r      <= 1'b0;
      shift_en_r <= 1'b0;
      steps_r    <= {CW{1'b0}};
      a_r        <= {W{1'b0}};
      lo_r       <= {W{1'b0}};
      hi_r       <= {W{1'b0}};
      carry_r    <= 1'b0;
    end else if (start) begin
      op_r       <= op;
      dir_r      <= dir;
      shift_en_r <= (count != {CW{1'b0}});
      a_r        <= a;
      lo_r       <= (op == MUL) ? b : a;
      hi_r       <= {W{1'b0}};
      carry_r    <= 1'b0;
      if (op == SHN) begin
        steps_r <= (count == {CW{1'b0}}) ? {{(CW-1){1'b0}}, 1'b1} : count;
      end else begin
        steps_r <= CW'(W);
      end
    end else if (run) begin
      lo_r    <= lo_s;
      hi_r    <= hi_s;
      carry_r <= carry_s;
      steps_r <= steps_r - {{(CW-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with START/BUSY/DONE handshake. Single-cycle ops complete
// at the sampling edge; SHN/MUL/POP run in alu_iter while BUSY is high.
module alu_seq
  import alu_pkg::*;
#(
  parameter int W    = 8,
  parameter int IMMW = 5,
  parameter int OFFW = W + 1
) (
  input  logic     CLK,
  input  logic     reset,
  alu_seq_if.slave bus
);

  localparam int CW = $clog2(W + 1);
  localparam int SW = $clog2(W);
  localparam logic [W-1:0] ONE_W = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] W_VAL = W'(W);

  state_t state_r, next_state_s;
  alu_op_t op_s;
  logic single_s, iter_start_s, iter_done_s;
  logic [CW-1:0] count_s;

  logic [W-1:0]    out_r, hi_r;
  logic            zero_r, carry_r, done_r, sign_r;
  logic [OFFW-1:0] off_r;

  logic [W:0]      add_s, sub_s;
  logic [W-1:0]    s_out, s_hi;
  logic            s_zero, s_carry, s_sign;
  logic [OFFW-1:0] s_off;

  logic [W-1:0]    it_lo, it_hi;
  logic            it_carry;

  assign op_s = alu_op_t'(bus.OP);
  // Saturate the shift count after a full-width compare so large B gives W.
  assign count_s = (bus.INPUTB >= W_VAL) ? CW'(W) : CW'(bus.INPUTB);

  alu_iter #(.W(W), .CW(CW)) u_iter (
    .clk       (CLK),
    .reset     (reset),
    .start     (iter_start_s),
    .run       (state_r == RUN),
    .op        (op_s),
    .dir       (bus.T),
    .a         (bus.INPUTA),
    .b         (bus.INPUTB),
    .count     (count_s),
    .done      (iter_done_s),
    .res_lo    (it_lo),
    .res_hi    (it_hi),
    .res_carry (it_carry)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and dispatch: START is only honoured in IDLE.
  always_comb begin
    next_state_s = state_r;
    single_s     = 1'b0;
    iter_start_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.START) begin
          if (is_iter(op_s)) begin
            iter_start_s = 1'b1;
            next_state_s = RUN;
          end else begin
            single_s = 1'b1;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        if (iter_done_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = RUN;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Single-cycle results; outputs an op does not define keep their value.
  always_comb begin
    add_s   = {1'b0, bus.INPUTA} + {1'b0, bus.INPUTB} + {{W{1'b0}}, bus.T};
    sub_s   = {1'b0, bus.INPUTB} - {1'b0, bus.INPUTA} - {{W{1'b0}}, bus.T};
    s_out   = out_r;
    s_hi    = {W{1'b0}};
    s_carry = 1'b0;
    s_off   = off_r;
    s_sign  = sign_r;
    case (op_s)
      ADD: begin
        s_out   = add_s[W-1:0];
        s_carry = add_s[W];
      end
      SUB: begin
        s_out   = sub_s[W-1:0];
        s_carry = sub_s[W];
      end
      XOR: s_out = bus.INPUTA ^ bus.INPUTB;
      GST: s_out = bus.T ? bus.INPUTB : bus.INPUTA;
      SH1: begin
        if (bus.T) begin
          s_out   = {1'b0, bus.INPUTA[W-1:1]};
          s_carry = bus.INPUTA[0];
        end else begin
          s_out   = {bus.INPUTA[W-2:0], 1'b0};
          s_carry = bus.INPUTA[W-1];
        end
      end
      ACC: s_out = W'(bus.IMM);
      ENQ: s_out = ((bus.INPUTA == bus.INPUTB) == bus.T) ? ONE_W : {W{1'b0}};
      EQI: s_out = ((bus.INPUTB == W'(bus.IMM)) == bus.T) ? ONE_W : {W{1'b0}};
      FBT: s_out = bus.INPUTB ^ (ONE_W << bus.IMM[SW-1:0]);
      BRC: begin
        if (bus.INPUTB == {W{1'b0}}) begin
          s_off  = OFFW'(bus.IMM[IMMW-2:0]);
          s_sign = bus.IMM[IMMW-1];
        end else begin
          s_off  = {{(OFFW-1){1'b0}}, 1'b1};
          s_sign = 1'b0;
        end
      end
      BRR: begin
        if (bus.INPUTB == {W{1'b0}}) begin
          s_off  = OFFW'(bus.INPUTA);
          s_sign = bus.T;
        end else begin
          s_off  = {{(OFFW-1){1'b0}}, 1'b1};
          s_sign = 1'b0;
        end
      end
      default: s_out = {W{1'b0}};
    endcase
    // Branches leave ZERO alone; everything else flags the new OUT.
    if (op_s == BRC || op_s == BRR) begin
      s_zero = zero_r;
    end else begin
      s_zero = (s_out == {W{1'b0}});
    end
  end

  // Result registers and the one-cycle DONE pulse.
  always_ff @(posedge CLK) begin
    if (reset) begin
      out_r   <= {W{1'b0}};
      hi_r    <= {W{1'b0}};
      zero_r  <= 1'b0;
      carry_r <= 1'b0;
      off_r   <= {OFFW{1'b0}};
      sign_r  <= 1'b0;
      done_r  <= 1'b0;
    end else if (single_s) begin
      out_r   <= s_out;
      hi_r    <= s_hi;
      zero_r  <= s_zero;
      carry_r <= s_carry;
      off_r   <= s_off;
      sign_r  <= s_sign;
      done_r  <= 1'b1;
    end else if (iter_done_s) begin
      out_r   <= it_lo;
      hi_r    <= it_hi;
      zero_r  <= (it_lo == {W{1'b0}}) && (it_hi == {W{1'b0}});
      carry_r <= it_carry;
      done_r  <= 1'b1;
    end else begin
      done_r  <= 1'b0;
    end
  end

  assign bus.OUT     = out_r;
  assign bus.OUT_HI  = hi_r;
  assign bus.ZERO    = zero_r;
  assign bus.CARRY   = carry_r;
  assign bus.BUSY    = (state_r == RUN);
  assign bus.DONE    = done_r;
  assign bus.bOFFSET = off_r;
  assign bus.bSIGN   = sign_r;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the single-cycle datapath ALU. Same accumulator-style operand roles: INPUTA = rs, INPUTB = r0, T = toggle bit.
- Adds a START/BUSY/DONE handshake, a carry flag, and three iterative multi-cycle ops: N-bit shift, multiply, popcount.
- Sits between register-file read and write-back. The controller stalls instruction fetch while BUSY is high.

Parameters:
- W, 8, datapath width (>=4, power of two).
- IMMW, 5, immediate width; IMM[IMMW-1] is the branch sign.
- OFFW, W+1, branch offset width.

Ports:
- CLK  in  1  clock
- reset  in  1  synchronous, active-high
- START  in  1  op request, sampled only in IDLE
- OP  in  4  opcode (alu_op_t)
- T  in  1  toggle bit
- INPUTA  in  W  rs operand
- INPUTB  in  W  r0 operand
- IMM  in  IMMW  instruction immediate
- OUT  out  W  result, low word
- OUT_HI  out  W  product high word (MUL only, else 0)
- ZERO  out  1  result == 0
- CARRY  out  1  carry/borrow/shift-out
- BUSY  out  1  multi-cycle op in progress
- DONE  out  1  one-cycle result-valid pulse
- bOFFSET  out  OFFW  branch offset magnitude
- bSIGN  out  1  branch direction (1 = backward)

Behaviour:
- Reset: state=IDLE; OUT, OUT_HI, ZERO, CARRY, BUSY, DONE, bOFFSET, bSIGN = 0. Reset mid-op aborts the op, and no DONE is produced.
- FSM states: IDLE, RUN.
  - IDLE & START & single-cycle op: result registered at that edge; DONE=1 for the following cycle; stay in IDLE.
  - IDLE & START & iterative op: latch operands and count; go to RUN with BUSY=1.
  - RUN: one step per edge. On the final step, register the result, DONE=1 for the next cycle, BUSY=0, return to IDLE.
- START while BUSY is ignored; operand changes during RUN are ignored. Back-to-back single-cycle ops give a DONE every cycle.
- Outputs hold their last value between ops. DONE is low otherwise.
- Single-cycle ops:
  - ADD: {CARRY,OUT} = A+B+T.
  - SUB: OUT = B-A-T; CARRY = borrow.
  - XOR: A^B.
  - GST: T ? B : A.
  - SH1: T ? A>>1 : A<<1; CARRY = bit shifted out.
  - ACC: zero-extended IMM.
  - ENQ: OUT = 1 if (A==B)==T, else 0.
  - EQI: as ENQ, comparing B with zero-extended IMM.
  - FBT: B ^ (1 << IMM[log2W-1:0]).
  - BRC: if B==0 then bOFFSET = zero-ext IMM[IMMW-2:0], bSIGN = IMM[IMMW-1]; else bOFFSET=1, bSIGN=0. OUT unchanged.
  - BRR: as BRC, but offset = A and sign = T.
  - Undefined opcodes: OUT=0, 1-cycle NOP with DONE.
- CARRY is cleared by every op that does not define it. OUT_HI is cleared by every op except MUL.
- Iterative ops (N = cycles in RUN):
  - SHN: shift A by count = min(B, W), direction T (1 = right, logical). One bit per cycle, so N = max(count,1). count 0 gives OUT=A, CARRY=0. count >= W gives OUT=0. CARRY = last bit shifted out.
  - MUL: unsigned shift-add, N = W. {OUT_HI,OUT} = A*B; CARRY = (OUT_HI != 0).
  - POP: N = W; OUT = number of 1s in A.
- ZERO: for MUL, (OUT_HI==0 && OUT==0); for BRC/BRR, unchanged; otherwise (OUT==0). ZERO is registered together with OUT.
- Widths: all arithmetic is modulo 2^W except the MUL product (2W). Shift count is compared at full width before saturation.

Decomposition:
- Package alu_pkg holds:
  - alu_op_t enum (ADD, SUB, XOR, GST, SH1, ACC, ENQ, EQI, FBT, BRC, BRR, SHN, MUL, POP);
  - state_t;
  - function is_iter(alu_op_t).
- One sub-module, alu_iter: the RUN-phase shift/multiply/popcount engine. It has start/op/count inputs and done/result outputs, and is parametrised by W.

Test Plan:
- W=8, ADD: A=8'hFF, B=8'h01, T=0 -> next cycle OUT=8'h00, CARRY=1, ZERO=1, DONE=1 for exactly one cycle, BUSY never high.
- MUL: A=8'hFF, B=8'hFF -> BUSY=1 for 8 cycles; then OUT=8'h01, OUT_HI=8'hFE, CARRY=1, ZERO=0, single DONE pulse.
- SHN boundaries:
  - A=8'h81, B=1, T=1 -> OUT=8'h40, CARRY=1, N=1.
  - B=0 -> OUT=8'h81, N=1.
  - B=200 -> OUT=0, ZERO=1, N=8.
- START asserted every cycle during POP of A=8'hB5 -> extra STARTs ignored; OUT=5 after 8 cycles; exactly one DONE.
- reset pulsed at cycle 3 of a MUL -> all outputs 0, IDLE, no DONE. A new ADD right after reset completes normally.
- BRC: B=0, IMM=5'b10011 -> bOFFSET=3, bSIGN=1. Same op with B=4 -> bOFFSET=1, bSIGN=0, OUT unchanged.
